// File: rtl/cache_backing_memory.sv
// cache_backing_memory: fixed-latency word-addressed backing store for cache fills and writebacks.
// Define MEM_BOUNDS_CHECK_EN to flag and suppress accesses beyond the array instead of aliasing.
`timescale 1ns/1ps
module cache_backing_memory #(
    parameter int data_width     = 32,
    parameter int address_width  = 16,
    parameter int mem_words_bits = 10,
    parameter int mem_latency    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [address_width-1:0] req_addr,
    input  logic [data_width-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [data_width-1:0]    resp_rdata
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic                     resp_err
`endif
);
    if (mem_latency < 1 || mem_latency > 15) begin : g_bad_latency
        $error("mem_latency must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [data_width-1:0]     rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      we, oor;
    logic [mem_words_bits-1:0] idx;
    logic [data_width-1:0]     mem [2**mem_words_bits] = '{default: '0};

    assign idx = req_addr[mem_words_bits+1:2];
`ifdef MEM_BOUNDS_CHECK_EN
    logic unused_addr;
    assign oor         = |req_addr[address_width-1:mem_words_bits+2];
    assign unused_addr = ^req_addr[1:0];
    assign resp_err    = err_q;
`else
    logic unused_addr;
    assign oor         = 1'b0;
    assign unused_addr = ^{req_addr[address_width-1:mem_words_bits+2], req_addr[1:0], err_q};
`endif

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we      = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT;
                cnt_d   = 4'(mem_latency - 1);
                rdata_d = (req_write || oor) ? '0 : mem[idx];
                err_d   = oor;
                we      = req_write && !oor;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
                cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // The array sits outside the reset so reset only abandons control state, never contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (we) mem[idx] <= req_wdata;
        end
    end
endmodule

// File: tb/tb_cache_backing_memory.sv
// tb_cache_backing_memory: scoreboard bench for a latency-4 and a latency-1 instance.
`timescale 1ns/1ps
module tb_cache_backing_memory;
    typedef struct {logic [31:0] d; logic e; int acc;} ent_t;

    logic             clk = 0, reset_n = 0;
    logic [1:0]       rv, rw, rr, rdy, vld, err;
    logic [1:0][15:0] ra;
    logic [1:0][31:0] wd, rd;
    ent_t             q0[$], q1[$];
    ent_t             cur[2];
    bit               active[2];
    int               cyc = 0, vectors = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_backing_memory #(.mem_latency(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(wd[0]), .resp_valid(vld[0]), .resp_ready(rr[0]), .resp_rdata(rd[0])
`ifdef MEM_BOUNDS_CHECK_EN
        , .resp_err(err[0])
`endif
    );
    cache_backing_memory #(.mem_latency(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(wd[1]), .resp_valid(vld[1]), .resp_ready(rr[1]), .resp_rdata(rd[1])
`ifdef MEM_BOUNDS_CHECK_EN
        , .resp_err(err[1])
`endif
    );
`ifndef MEM_BOUNDS_CHECK_EN
    assign err = 2'b00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic mon(input int s);
        if (!reset_n || !vld[s]) begin
            active[s] = 0;
            return;
        end
        if (!active[s]) begin
            active[s] = 1;
            if ((s ? q1.size() : q0.size()) == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_resp dut%0d: got rdata %h expected no response", s, rd[s]);
                cur[s].d = rd[s];
                cur[s].e = err[s];
                return;
            end
            cur[s] = s ? q1.pop_front() : q0.pop_front();
            check($sformatf("latency_dut%0d", s), cyc - cur[s].acc, s ? 1 : 4);
        end
        check($sformatf("rdata_dut%0d", s), rd[s], cur[s].d);
        check($sformatf("err_dut%0d", s), err[s], cur[s].e);
        if (rr[s]) active[s] = 0;
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    task automatic req(input int s, input bit w, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input bit e, input bit push);
        int   n = 0;
        ent_t x;
        while (!rdy[s]) begin
            @(negedge clk);
            if (++n > 100) begin
                timeout("req_ready_wait");
                return;
            end
        end
        rv[s] = 1; rw[s] = w; ra[s] = a; wd[s] = d;
        @(posedge clk);
        #1;
        if (push) begin
            x.d = exp; x.e = e; x.acc = cyc;
            if (s) q1.push_back(x);
            else q0.push_back(x);
        end
        @(negedge clk);
        rv[s] = 0;
    endtask

    task automatic drain(input int s);
        int n = 0;
        while ((s ? q1.size() : q0.size()) != 0 || vld[s] || !rdy[s]) begin
            @(negedge clk);
            if (++n > 200) begin
                timeout("drain");
                return;
            end
        end
    endtask

    initial begin
        int n;
        rv = '0; rw = '0; rr = '1; ra = '0; wd = '0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (10) begin
            @(negedge clk);
            check("idle_ready", rdy[0], 1);
            check("idle_valid", vld[0], 0);
            check("idle_rdata", rd[0], 0);
        end
        req(0, 1, 16'h0010, 32'hDEADBEEF, 32'h0, 0, 1);
        req(0, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 1);
        drain(0);
        rr[0] = 0;
        req(0, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 1);
        n = 0;
        while (!vld[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!vld[0]) timeout("hold_resp_wait");
        rv[0] = 1; rw[0] = 1; ra[0] = 16'h0040; wd[0] = 32'h55555555;
        repeat (6) begin
            @(negedge clk);
            check("hold_ready", rdy[0], 0);
            check("hold_valid", vld[0], 1);
        end
        rr[0] = 1;
        @(negedge clk);
        check("ready_after_hs", rdy[0], 1);
        check("valid_after_hs", vld[0], 0);
        rv[0] = 0;
        req(0, 0, 16'h0040, 32'h0, 32'h0, 0, 1);
        drain(0);
        req(0, 1, 16'h0020, 32'hCAFEF00D, 32'h0, 0, 0);
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (8) begin
            @(negedge clk);
            check("no_resp_after_reset", vld[0], 0);
        end
        req(0, 0, 16'h0020, 32'h0, 32'hCAFEF00D, 0, 1);
        drain(0);
`ifdef MEM_BOUNDS_CHECK_EN
        req(0, 1, 16'h1010, 32'h12345678, 32'h0, 1, 1);
        req(0, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 1);
        req(0, 0, 16'h1010, 32'h0, 32'h0, 1, 1);
`else
        req(0, 1, 16'h1010, 32'h12345678, 32'h0, 0, 1);
        req(0, 0, 16'h0010, 32'h0, 32'h12345678, 0, 1);
`endif
        drain(0);
        req(1, 1, 16'h0000, 32'h11111111, 32'h0, 0, 1);
        req(1, 1, 16'h0004, 32'h22222222, 32'h0, 0, 1);
        req(1, 0, 16'h0000, 32'h0, 32'h11111111, 0, 1);
        req(1, 0, 16'h0004, 32'h0, 32'h22222222, 0, 1);
        drain(1);
        check("queues_empty", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
